// File: rtl/regfile_dump_reader_pkg.sv
// Shared types and constants for the register-file dump reader.
package regfile_dump_reader_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned NREGS     = 32;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StFetch   = 2'd1,
    StPresent = 2'd2,
    StDone    = 2'd3
  } dump_state_e;

  // Next register index, wrapping from the top of the register file back to 0.
  function automatic logic [REG_IDX_W-1:0] next_idx(input logic [REG_IDX_W-1:0] idx,
                                                    input logic [REG_IDX_W-1:0] idx_max);
    return (idx == idx_max) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/regfile_dump_ptr.sv
// Wrapping register-index walker: loads a [first, last] range, steps one index at a time,
// and flags when the current index is the inclusive end of the range.
module regfile_dump_ptr
  import regfile_dump_reader_pkg::*;
#(
  parameter int unsigned NREGS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic [REG_IDX_W-1:0] first_i,
  input  logic [REG_IDX_W-1:0] last_i,
  input  logic                 inc_i,
  output logic [REG_IDX_W-1:0] ptr_o,
  output logic                 at_last_o
);

  localparam logic [REG_IDX_W-1:0] IdxMax = REG_IDX_W'(NREGS - 1);

  logic [REG_IDX_W-1:0] ptr_q, ptr_d;
  logic [REG_IDX_W-1:0] last_q, last_d;

  always_comb begin
    ptr_d  = ptr_q;
    last_d = last_q;
    if (load_i) begin
      ptr_d  = first_i;
      last_d = last_i;
    end else if (inc_i) begin
      ptr_d = next_idx(ptr_q, IdxMax);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q  <= '0;
      last_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      last_q <= last_d;
    end
  end

  assign ptr_o     = ptr_q;
  assign at_last_o = (ptr_q == last_q);

endmodule

// File: rtl/regfile_dump_reader.sv
// Read-side dump initiator: walks a latched register range through one register-file read
// port and streams each captured word, tagged with its index, on a valid/ready interface.
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int unsigned N         = 32,
  parameter int unsigned NREGS     = 32,
  parameter bit          SKIP_ZERO = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [REG_IDX_W-1:0] first_reg_i,
  input  logic [REG_IDX_W-1:0] last_reg_i,
  output logic [REG_IDX_W-1:0] Read_Register_o,
  input  logic [N-1:0]         Read_Data_i,
  output logic                 dump_valid_o,
  input  logic                 dump_ready_i,
  output logic [N-1:0]         dump_data_o,
  output logic [REG_IDX_W-1:0] dump_addr_o,
  output logic                 busy_o,
  output logic                 done_o
);

  dump_state_e state_q, state_d;

  logic [REG_IDX_W-1:0] ptr;
  logic                 at_last;
  logic                 ptr_load;
  logic                 ptr_inc;
  logic                 capture;
  logic                 skip_cur;
  logic                 handshake;

  logic                 valid_q, valid_d;
  logic [N-1:0]         data_q, data_d;
  logic [REG_IDX_W-1:0] addr_q, addr_d;

  regfile_dump_ptr #(
    .NREGS(NREGS)
  ) u_ptr (
    .clk      (clk),
    .reset    (reset),
    .load_i   (ptr_load),
    .first_i  (first_reg_i),
    .last_i   (last_reg_i),
    .inc_i    (ptr_inc),
    .ptr_o    (ptr),
    .at_last_o(at_last)
  );

  assign skip_cur  = SKIP_ZERO && (ptr == '0);
  // valid_q is only ever set in PRESENT, so ready is ignored everywhere else.
  assign handshake = valid_q && dump_ready_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start_i) state_d = StFetch;
      end
      StFetch: begin
        if (!skip_cur) begin
          state_d = StPresent;
        end else if (at_last) begin
          state_d = StDone;
        end
      end
      StPresent: begin
        if (handshake) state_d = at_last ? StDone : StFetch;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    ptr_load = 1'b0;
    ptr_inc  = 1'b0;
    capture  = 1'b0;
    case (state_q)
      StIdle:    ptr_load = start_i;
      StFetch: begin
        capture = !skip_cur;
        ptr_inc = skip_cur && !at_last;
      end
      StPresent: ptr_inc = handshake && !at_last;
      default: ;
    endcase
  end

  assign busy_o = (state_q != StIdle);
  assign done_o = (state_q == StDone);

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    addr_d  = addr_q;
    if (capture) begin
      valid_d = 1'b1;
      data_d  = Read_Data_i;
      addr_d  = ptr;
    end else if (handshake) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
    end
  end

  // The read address is the registered walk pointer, so the port never glitches.
  assign Read_Register_o = ptr;
  assign dump_valid_o    = valid_q;
  assign dump_data_o     = data_q;
  assign dump_addr_o     = addr_q;

  a_hold_until_accept: assert property (@(posedge clk) disable iff (reset)
    valid_q && !dump_ready_i |=> valid_q && $stable(data_q) && $stable(addr_q));

  a_valid_only_in_present: assert property (@(posedge clk) disable iff (reset)
    valid_q |-> state_q == StPresent);

endmodule
